// File: rtl/argmax_collect.sv
// argmax_collect: packs up to 2**S unsigned samples into one frame for a downstream argmax tree
// Ports: clk, rst_n (async active-low); in_data_i/in_valid_i/in_last_i/in_ready_o form the sample
// stream, and in_last_i may close a frame early; out_vec_o (slot 0 = first sample), out_count_o and
// out_valid_o hold the frame until out_ready_i.
module argmax_collect #(
  parameter int S = 3,
  parameter int M = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [M-1:0]          in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [M*(2**S)-1:0]   out_vec_o,
  output logic [S:0]            out_count_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);
  localparam int N = 2**S;
  typedef enum logic {FILL, FULL} state_t;
  state_t         state_q;
  logic [S:0]     wr_ptr_q, count_q;
  logic [M*N-1:0] vec_q;
  logic           accept, close;
  assign accept = in_valid_i && state_q == FILL;
  // in_last on the beat that fills the last slot is a single close, never an extra empty frame
  assign close = in_last_i || wr_ptr_q == (S+1)'(N-1);
  // unused slots stay zero because every slot is cleared on handshake and on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= FILL;
      wr_ptr_q <= '0;
      count_q  <= '0;
      vec_q    <= '0;
    end else if (state_q == FULL) begin
      if (out_ready_i) begin
        state_q  <= FILL;
        wr_ptr_q <= '0;
        count_q  <= '0;
        vec_q    <= '0;
      end
    end else if (accept) begin
      vec_q[wr_ptr_q[S-1:0]*M +: M] <= in_data_i;
      wr_ptr_q <= wr_ptr_q + 1'b1;
      if (close) begin
        state_q <= FULL;
        count_q <= wr_ptr_q + 1'b1;
      end
    end
  assign in_ready_o  = state_q == FILL;
  assign out_valid_o = state_q == FULL;
  assign out_vec_o   = vec_q;
  assign out_count_o = count_q;
endmodule

// File: tb/tb_argmax_collect.sv
// tb_argmax_collect: directed plus randomized frames checked against a frame-level queue model
module tb_argmax_collect;
  localparam int S = 2, M = 8, N = 4;
  logic clk = 0, rst_n = 0;
  logic [M-1:0] in_data = '0;
  logic in_valid = 0, in_last = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [M*N-1:0] out_vec;
  logic [S:0] out_count;
  int checks = 0, failures = 0;
  bit m_full = 0;
  logic [7:0] cur[$], frm[$];
  logic [7:0] x;
  int len;

  argmax_collect #(.S(S), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .out_vec_o(out_vec), .out_count_o(out_count), .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack();
    logic [31:0] v = '0;
    foreach (frm[k]) v[k*8 +: 8] = frm[k];
    return v;
  endfunction

  task automatic check_outs();
    chk("in_ready", in_ready, !m_full);
    chk("out_valid", out_valid, m_full);
    if (m_full) begin
      chk("out_vec", out_vec, pack());
      chk("out_count", out_count, frm.size());
    end
  endtask

  task automatic cycle();
    bit acc, hs;
    acc = in_valid && !m_full;
    hs  = out_ready && m_full;
    @(posedge clk);
    #1;
    if (hs) begin
      m_full = 0;
      frm = {};
    end else if (acc) begin
      cur.push_back(in_data);
      if (in_last || cur.size() == N) begin
        frm = cur;
        cur = {};
        m_full = 1;
      end
    end
    check_outs();
  endtask

  task automatic beat(input logic [7:0] d, input bit l);
    in_valid = 1;
    in_data  = d;
    in_last  = l;
    cycle();
    in_valid = 0;
    in_last  = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic handshake();
    out_ready = 1;
    cycle();
    out_ready = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    #2;
    m_full = 0;
    cur = {};
    frm = {};
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_count", out_count, 0);
    @(posedge clk);
    #3;
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    // back-to-back 5,9,3,7 then held with no consumer
    beat(8'd5, 0); beat(8'd9, 0); beat(8'd3, 0); beat(8'd7, 1);
    chk("r031_vec", out_vec, 32'h07030905);
    chk("r031_count", out_count, 4);
    idle(10);
    chk("r031_hold_vec", out_vec, 32'h07030905);
    handshake();
    // short frame with zero padding, then first beat of next frame in slot 0
    beat(8'h11, 0); beat(8'h22, 1);
    chk("r032_vec", out_vec, 32'h00002211);
    chk("r032_count", out_count, 2);
    handshake();
    beat(8'hAA, 0); beat(8'($urandom), 0); beat(8'($urandom), 1);
    chk("r032_slot0", out_vec[7:0], 8'hAA);
    handshake();
    // fifth beat held by backpressure, not taken in the handshake cycle
    repeat (4) beat(8'($urandom), 0);
    x = 8'($urandom);
    in_valid = 1; in_data = x; in_last = 0;
    idle(3);
    out_ready = 1;
    cycle();
    out_ready = 0;
    cycle();
    in_valid = 0;
    repeat (3) beat(8'($urandom), 0);
    chk("r033_slot0", out_vec[7:0], x);
    handshake();
    // gaps between beats do not advance the write pointer
    beat(8'd1, 0); idle(1); beat(8'd2, 0); idle(1); beat(8'd3, 0); idle(1); beat(8'd4, 1);
    chk("r034_vec", out_vec, 32'h04030201);
    handshake();
    idle(2);
    // reset mid-frame discards partial data
    beat(8'($urandom), 0); beat(8'($urandom), 0);
    do_reset();
    repeat (4) beat(8'd8, 0);
    chk("r035_vec", out_vec, 32'h08080808);
    chk("r035_count", out_count, 4);
    // reset while full
    do_reset();
    beat(8'h5A, 1);
    chk("r036_slot0", out_vec, 32'h0000005A);
    handshake();
    // randomized frames with random gaps and consumer delay
    repeat (40) begin
      len = $urandom_range(1, N);
      for (int i = 0; i < len; i++) begin
        beat(8'($urandom), (i == len - 1) && (len < N || $urandom_range(0, 1) == 1));
        idle($urandom_range(0, 2));
      end
      idle($urandom_range(0, 3));
      handshake();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
